// File: rtl/linear_ctl.sv
// rtl/linear_ctl.sv - gain/offset configuration sequencer for the linear stream stage
// Applies shadowed cfg_mul/cfg_sum immediately, at end of packet, or as a per-transfer gain ramp.
module linear_ctl #(
  parameter int DWM = 16,
  parameter int DWS = 14,
  parameter logic [DWM-1:0] MUL_RST = DWM'(2**(DWM-2)),
  parameter logic [DWS-1:0] SUM_RST = '0
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic [DWM-1:0] reg_mul,
  input  logic [DWS-1:0] reg_sum,
  input  logic [1:0]     reg_mode,
  input  logic [DWM-2:0] reg_step,
  input  logic           reg_wen,
  input  logic           reg_abort,
  input  logic           str_tvalid,
  input  logic           str_tready,
  input  logic           str_tlast,
  output logic [DWM-1:0] cfg_mul,
  output logic [DWS-1:0] cfg_sum,
  output logic           sts_busy,
  output logic           sts_done
);

  typedef enum logic [1:0] {IDLE, WAIT_EOP, RAMP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [DWM-1:0] r_mul;
  logic [DWS-1:0] r_sum;
  logic [DWM-1:0] r_tgt_mul;
  logic [DWS-1:0] r_tgt_sum;
  logic [DWM-2:0] r_step;
  logic           r_busy;
  logic           r_done;

  logic           w_xfer;
  logic           w_eop;
  logic           w_imm;
  logic [DWM:0]   w_diff;
  logic [DWM:0]   w_abs;
  logic           w_ramp_last;
  logic [DWM-1:0] w_ramp_mul;
  logic [DWM-1:0] w_mul_nxt;
  logic [DWS-1:0] w_sum_nxt;
  logic           w_done_nxt;

  assign w_xfer = str_tvalid & str_tready;
  assign w_eop  = w_xfer & str_tlast;
  // Reserved mode and a zero-step ramp both collapse to an immediate apply.
  assign w_imm  = (reg_mode == 2'd0) || (reg_mode == 2'd3) ||
                  ((reg_mode == 2'd2) && (reg_step == '0));

  // Distance to target carried one bit wider so full-scale swings cannot wrap.
  assign w_diff      = {r_tgt_mul[DWM-1], r_tgt_mul} - {r_mul[DWM-1], r_mul};
  assign w_abs       = w_diff[DWM] ? (~w_diff + 1'b1) : w_diff;
  assign w_ramp_last = (w_abs <= {2'b00, r_step});
  assign w_ramp_mul  = w_diff[DWM] ? (r_mul - {1'b0, r_step}) : (r_mul + {1'b0, r_step});

  always_comb begin
    w_state_nxt = r_state;
    w_mul_nxt   = r_mul;
    w_sum_nxt   = r_sum;
    w_done_nxt  = 1'b0;
    if (reg_wen) begin
      if (w_imm) begin
        w_mul_nxt   = reg_mul;
        w_sum_nxt   = reg_sum;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end else if (reg_mode == 2'd1) begin
        w_state_nxt = WAIT_EOP;
      end else begin
        w_state_nxt = RAMP;
      end
    end else begin
      case (r_state)
        WAIT_EOP: begin
          if (reg_abort) begin
            w_state_nxt = IDLE;
          end else if (w_eop) begin
            w_mul_nxt   = r_tgt_mul;
            w_sum_nxt   = r_tgt_sum;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        RAMP: begin
          if (reg_abort) begin
            w_state_nxt = IDLE;
          end else if (w_xfer) begin
            if (w_ramp_last) begin
              w_mul_nxt   = r_tgt_mul;
              w_sum_nxt   = r_tgt_sum;
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_mul_nxt = w_ramp_mul;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= IDLE;
      r_mul     <= MUL_RST;
      r_sum     <= SUM_RST;
      r_tgt_mul <= MUL_RST;
      r_tgt_sum <= SUM_RST;
      r_step    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mul   <= w_mul_nxt;
      r_sum   <= w_sum_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
      if (reg_wen) begin
        r_tgt_mul <= reg_mul;
        r_tgt_sum <= reg_sum;
        r_step    <= reg_step;
      end
    end
  end

  assign cfg_mul  = r_mul;
  assign cfg_sum  = r_sum;
  assign sts_busy = r_busy;
  assign sts_done = r_done;

endmodule

// File: tb/tb_linear_ctl.sv
// tb/tb_linear_ctl.sv - directed scoreboard bench for linear_ctl
module tb_linear_ctl;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [15:0] reg_mul;
  logic [13:0] reg_sum;
  logic [1:0]  reg_mode;
  logic [14:0] reg_step;
  logic        reg_wen, reg_abort;
  logic        str_tvalid, str_tready, str_tlast;
  logic [15:0] cfg_mul;
  logic [13:0] cfg_sum;
  logic        sts_busy, sts_done;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       tag;
    logic [15:0] mul;
    logic [13:0] sum;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];

  linear_ctl dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .reg_mul(reg_mul), .reg_sum(reg_sum), .reg_mode(reg_mode), .reg_step(reg_step),
    .reg_wen(reg_wen), .reg_abort(reg_abort),
    .str_tvalid(str_tvalid), .str_tready(str_tready), .str_tlast(str_tlast),
    .cfg_mul(cfg_mul), .cfg_sum(cfg_sum), .sts_busy(sts_busy), .sts_done(sts_done)
  );

  always #5 ACLK = ~ACLK;

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    n_chk++;
    assert (cfg_mul === e.mul) n_pass++;
    else $error("FAIL %s cfg_mul obs=%0d exp=%0d", e.tag, $signed(cfg_mul), $signed(e.mul));
    n_chk++;
    assert (cfg_sum === e.sum) n_pass++;
    else $error("FAIL %s cfg_sum obs=%0d exp=%0d", e.tag, $signed(cfg_sum), $signed(e.sum));
    n_chk++;
    assert (sts_busy === e.busy) n_pass++;
    else $error("FAIL %s sts_busy obs=%b exp=%b", e.tag, sts_busy, e.busy);
    n_chk++;
    assert (sts_done === e.done) n_pass++;
    else $error("FAIL %s sts_done obs=%b exp=%b", e.tag, sts_done, e.done);
  endtask

  // Queue the expectation for the coming edge, clock, then compare; strobes are one cycle.
  task automatic tick(input string tag, input int mul, input int sum, input logic busy, input logic done);
    exp_t e;
    e.tag = tag; e.mul = 16'(mul); e.sum = 14'(sum); e.busy = busy; e.done = done;
    sb.push_back(e);
    @(posedge ACLK);
    #1;
    compare_head();
    reg_wen   = 1'b0;
    reg_abort = 1'b0;
  endtask

  task automatic wr(input int mode, input int mul, input int sum, input int step);
    reg_wen  = 1'b1;
    reg_mode = 2'(mode);
    reg_mul  = 16'(mul);
    reg_sum  = 14'(sum);
    reg_step = 15'(step);
  endtask

  initial begin
    ARESETn = 1'b0;
    reg_mul = '0; reg_sum = '0; reg_mode = '0; reg_step = '0;
    reg_wen = 1'b0; reg_abort = 1'b0;
    str_tvalid = 1'b0; str_tready = 1'b0; str_tlast = 1'b0;

    tick("rst", 16384, 0, 1'b0, 1'b0);
    ARESETn = 1'b1;
    tick("rst_rel", 16384, 0, 1'b0, 1'b0);

    wr(0, 8192, -100, 0);
    tick("m0_apply", 8192, -100, 1'b0, 1'b1);
    tick("m0_hold", 8192, -100, 1'b0, 1'b0);

    wr(1, -16384, 50, 0);
    tick("m1_wr", 8192, -100, 1'b1, 1'b0);
    str_tvalid = 1'b1; str_tready = 1'b1;
    for (int i = 0; i < 6; i++) tick("m1_mid", 8192, -100, 1'b1, 1'b0);
    str_tlast = 1'b1;
    tick("m1_eop", -16384, 50, 1'b0, 1'b1);
    str_tvalid = 1'b0; str_tlast = 1'b0;
    tick("m1_after", -16384, 50, 1'b0, 1'b0);

    wr(3, 16384, 0, 0);
    tick("m3_apply", 16384, 0, 1'b0, 1'b1);
    wr(2, 16000, 77, 100);
    tick("r1_wr", 16384, 0, 1'b1, 1'b0);
    str_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int em;
      em = (k == 3) ? 16000 : 16284 - 100 * k;
      str_tready = 1'b1;
      tick("r1_xfer", em, (k == 3) ? 77 : 0, k != 3, k == 3);
      str_tready = 1'b0;
      tick("r1_stall", em, (k == 3) ? 77 : 0, k != 3, 1'b0);
    end
    str_tvalid = 1'b0;

    wr(0, 16384, 0, 0);
    tick("r2_pre", 16384, 0, 1'b0, 1'b1);
    wr(2, -32768, -5, 16383);
    tick("r2_wr", 16384, 0, 1'b1, 1'b0);
    str_tvalid = 1'b1; str_tready = 1'b1;
    tick("r2_s1", 1, 0, 1'b1, 1'b0);
    tick("r2_s2", -16382, 0, 1'b1, 1'b0);
    tick("r2_s3", -32765, 0, 1'b1, 1'b0);
    tick("r2_end", -32768, -5, 1'b0, 1'b1);
    str_tvalid = 1'b0;

    wr(0, 16384, 0, 0);
    tick("r3_pre", 16384, 0, 1'b0, 1'b1);
    wr(2, 0, 33, 1000);
    tick("r3_wr", 16384, 0, 1'b1, 1'b0);
    str_tvalid = 1'b1;
    for (int i = 1; i <= 3; i++) tick("r3_step", 16384 - 1000 * i, 0, 1'b1, 1'b0);
    str_tvalid = 1'b0; reg_abort = 1'b1;
    tick("r3_abort", 13384, 0, 1'b0, 1'b0);
    str_tvalid = 1'b1;
    tick("r3_frozen", 13384, 0, 1'b0, 1'b0);
    tick("r3_frozen", 13384, 0, 1'b0, 1'b0);
    str_tvalid = 1'b0;

    wr(1, 500, 9, 0);
    tick("c_wr", 13384, 0, 1'b1, 1'b0);
    str_tvalid = 1'b1;
    tick("c_xfer", 13384, 0, 1'b1, 1'b0);
    str_tlast = 1'b1; reg_abort = 1'b1;
    wr(0, 1000, 1, 0);
    tick("c_collide", 1000, 1, 1'b0, 1'b1);
    str_tvalid = 1'b0; str_tlast = 1'b0;
    tick("c_one_done", 1000, 1, 1'b0, 1'b0);
    tick("c_one_done", 1000, 1, 1'b0, 1'b0);

    wr(2, 200, 2, 0);
    tick("z_step", 200, 2, 1'b0, 1'b1);
    wr(2, 5000, 7, 100);
    tick("x_wr", 200, 2, 1'b1, 1'b0);
    str_tvalid = 1'b1;
    tick("x_step", 300, 2, 1'b1, 1'b0);
    #2 ARESETn = 1'b0;
    #1;
    begin
      exp_t e;
      e.tag = "x_async_rst"; e.mul = 16'd16384; e.sum = 14'd0; e.busy = 1'b0; e.done = 1'b0;
      sb.push_back(e);
      compare_head();
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick("x_lost", 16384, 0, 1'b0, 1'b0);
    tick("x_lost", 16384, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
